argmax_scan_ctrl: RTL and testbench

- Sequencer that drives the 32-bit two-input max-compare rule serially over a score memory of N_CLASSES entries.
- It reads one score per clock from a synchronous-read score RAM, which holds the output layer of the one-by-N classifier.
- It tracks the running maximum and its index.
- On completion it reports the winning class index and value with a one-cycle done pulse.

---
 rtl/argmax_scan_ctrl.sv | 130 +++++++++++++
 tb/tb_argmax_scan_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/argmax_scan_ctrl.sv
// ---------------------------------------------------------------------------
// argmax_scan_ctrl
//
// Purpose:
//   Scans a synchronous-read score RAM of N_CLASSES unsigned entries, one
//   read per clock. It tracks the running maximum and its index, then reports
//   the winner with a one-cycle done pulse. On a tie the lower index wins.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   start    in   begin a scan (sampled only while idle)
//   rd_en    out  score RAM read enable
//   rd_addr  out  score RAM address
//   rd_data  in   score RAM data, valid the cycle after rd_en
//   busy     out  scan in progress (RUN or DRAIN)
//   done     out  one-cycle pulse when max_val/max_idx are updated
//   max_val  out  winning score of the last completed scan
//   max_idx  out  winning index of the last completed scan
//
// Handshake: no ready/valid back-pressure. The RAM returns data exactly one
// cycle after rd_en. start is a level sampled only in IDLE. done is a pulse
// that qualifies max_val/max_idx, which then hold until the next done.
// ---------------------------------------------------------------------------
module argmax_scan_ctrl #(
    parameter int N_CLASSES = 10,
    parameter int DATA_W    = 32,
    parameter int IDX_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              rd_en,
    output logic [IDX_W-1:0]  rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] max_val,
    output logic [IDX_W-1:0]  max_idx
);

    localparam logic [IDX_W-1:0] LAST_ADDR = IDX_W'(N_CLASSES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    logic              pending;   // rd_data is valid this cycle
    logic              first;     // next valid data seeds the running max
    logic [IDX_W-1:0]  cap_idx;   // address that produced the current rd_data
    logic [DATA_W-1:0] work_val;
    logic [IDX_W-1:0]  work_idx;

    logic [DATA_W-1:0] work_val_next;
    logic [IDX_W-1:0]  work_idx_next;
    logic              first_next;

    // Running-max update. It is combinational so that the DRAIN edge can load
    // the results including the last word read.
    always_comb begin
        work_val_next = work_val;
        work_idx_next = work_idx;
        first_next    = first;
        if (pending) begin
            first_next = 1'b0;
            if (first || (rd_data > work_val)) begin
                work_val_next = rd_data;
                work_idx_next = cap_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            max_val  <= '0;
            max_idx  <= '0;
            pending  <= 1'b0;
            first    <= 1'b0;
            cap_idx  <= '0;
            work_val <= '0;
            work_idx <= '0;
        end else begin
            done     <= 1'b0;
            pending  <= rd_en;
            cap_idx  <= rd_addr;
            work_val <= work_val_next;
            work_idx <= work_idx_next;
            first    <= first_next;

            case (state)
                IDLE: begin
                    if (start) begin
                        rd_en   <= 1'b1;
                        rd_addr <= '0;
                        busy    <= 1'b1;
                        first   <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (rd_addr == LAST_ADDR) begin
                        rd_en <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        rd_addr <= rd_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    max_val <= work_val_next;
                    max_idx <= work_idx_next;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_argmax_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_argmax_scan_ctrl
//
// Purpose: self-checking bench for argmax_scan_ctrl. There are two instances:
// one with N_CLASSES=10 and one with N_CLASSES=1. Each has its own behavioural
// synchronous-read score RAM.
// ---------------------------------------------------------------------------
module tb_argmax_scan_ctrl;

    localparam int N      = 10;
    localparam int DATA_W = 32;
    localparam int IDX_W  = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT (N=10) ----------------
    logic              start;
    logic              rd_en;
    logic [IDX_W-1:0]  rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] max_val;
    logic [IDX_W-1:0]  max_idx;
    logic [DATA_W-1:0] ram [0:N-1];

    argmax_scan_ctrl #(.N_CLASSES(N), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done), .max_val(max_val), .max_idx(max_idx)
    );

    always @(posedge clk) begin
        if (rd_en && (int'(rd_addr) < N)) rd_data <= ram[rd_addr];
    end

    // ---------------- DUT (N=1) ----------------
    logic              start1;
    logic              rd_en1;
    logic [IDX_W-1:0]  rd_addr1;
    logic [DATA_W-1:0] rd_data1;
    logic              busy1;
    logic              done1;
    logic [DATA_W-1:0] max_val1;
    logic [IDX_W-1:0]  max_idx1;
    logic [DATA_W-1:0] ram1_0;

    argmax_scan_ctrl #(.N_CLASSES(1), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
        .busy(busy1), .done(done1), .max_val(max_val1), .max_idx(max_idx1)
    );

    always @(posedge clk) begin
        if (rd_en1) rd_data1 <= ram1_0;
    end

    // ---------------- scoreboard ----------------
    logic [IDX_W+DATA_W-1:0] exp_q [$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pops one expected result for every done pulse of the N=10 instance.
    always @(negedge clk) begin
        logic [IDX_W+DATA_W-1:0] e;
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("max_idx", 32'(max_idx), 32'(e[IDX_W+DATA_W-1:DATA_W]));
                check("max_val", max_val, e[DATA_W-1:0]);
            end
        end
        if (rd_en && (int'(rd_addr) > N - 1)) check("rd_addr_range", 32'(rd_addr), 32'(N - 1));
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference argmax: strictly greater-than, so the lowest index wins a tie.
    function automatic logic [IDX_W+DATA_W-1:0] ref_argmax();
        logic [DATA_W-1:0] bv = ram[0];
        logic [IDX_W-1:0]  bi = '0;
        for (int i = 1; i < N; i++) begin
            if (ram[i] > bv) begin
                bv = ram[i];
                bi = IDX_W'(i);
            end
        end
        return {bi, bv};
    endfunction

    // Runs one full scan and checks the address sequence and latency.
    // The call returns in the done cycle, so a following call asserts start
    // in that same cycle.
    task automatic run_scan(input logic [IDX_W-1:0] ex_idx,
                            input logic [DATA_W-1:0] ex_val,
                            input bit restart_mid);
        exp_q.push_back({ex_idx, ex_val});
        start = 1'b1;
        tick();                       // start edge
        start = 1'b0;
        for (int k = 0; k < N; k++) begin
            check("run_rd_en", 32'(rd_en), 32'd1);
            check("run_rd_addr", 32'(rd_addr), 32'(k));
            check("run_busy", 32'(busy), 32'd1);
            start = (restart_mid && k == 2) ? 1'b1 : 1'b0;
            tick();
        end
        start = 1'b0;
        check("drain_rd_en", 32'(rd_en), 32'd0);
        check("drain_busy", 32'(busy), 32'd1);
        check("drain_done", 32'(done), 32'd0);
        tick();                       // N+1 clocks after the start edge
        check("done_latency", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [IDX_W+DATA_W-1:0] m;
        rst    = 1'b1;
        start  = 1'b0;
        start1 = 1'b0;
        ram1_0 = '0;
        for (int i = 0; i < N; i++) ram[i] = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_max_val", max_val, 32'd0);
        check("rst_max_idx", 32'(max_idx), 32'd0);

        // 1: basic scan
        ram = '{5, 9, 3, 12, 7, 1, 0, 20, 4, 2};
        run_scan(4'd7, 32'd20, 1'b0);
        repeat (3) tick();
        check("hold_max_val", max_val, 32'd20);
        check("hold_max_idx", 32'(max_idx), 32'd7);

        // 2: ties keep the lower index; all-zero RAM
        ram = '{3, 8, 8, 1, 8, 0, 0, 0, 0, 0};
        run_scan(4'd1, 32'd8, 1'b0);
        tick();
        ram = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_scan(4'd0, 32'd0, 1'b0);
        tick();

        // 3: unsigned comparison
        ram = '{32'h7FFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF};
        run_scan(4'd9, 32'hFFFF_FFFF, 1'b0);
        tick();

        // 4: start while busy is ignored
        ram = '{5, 9, 3, 12, 7, 1, 0, 20, 4, 2};
        run_scan(4'd7, 32'd20, 1'b1);
        repeat (4) tick();

        // 5: reset mid-scan abandons it and clears the results
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("pre_rst_rd_addr", 32'(rd_addr), 32'(k));
            if (k < 4) tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_rd_en", 32'(rd_en), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_max_val", max_val, 32'd0);
        check("abort_max_idx", 32'(max_idx), 32'd0);
        repeat (14) tick();          // any stray done is caught by the scoreboard
        run_scan(4'd7, 32'd20, 1'b0);

        // 6: back-to-back scan, start asserted in the done cycle
        ram = '{1, 2, 99, 3, 4, 5, 6, 7, 8, 9};
        run_scan(4'd2, 32'd99, 1'b0);
        tick();

        // random contents against the reference model
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < N; i++) ram[i] = 32'($urandom_range(0, 15));
            m = ref_argmax();
            run_scan(m[IDX_W+DATA_W-1:DATA_W], m[DATA_W-1:0], 1'b0);
        end
        repeat (2) tick();

        // N_CLASSES=1 instance
        ram1_0 = 32'd42;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("n1_rd_en", 32'(rd_en1), 32'd1);
        check("n1_rd_addr", 32'(rd_addr1), 32'd0);
        tick();
        check("n1_drain_rd_en", 32'(rd_en1), 32'd0);
        check("n1_drain_done", 32'(done1), 32'd0);
        check("n1_drain_busy", 32'(busy1), 32'd1);
        tick();
        check("n1_done", 32'(done1), 32'd1);
        check("n1_max_val", max_val1, 32'd42);
        check("n1_max_idx", 32'(max_idx1), 32'd0);
        tick();
        check("n1_done_pulse", 32'(done1), 32'd0);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
